// File: rtl/ex_mem_stack_unit.sv
// EX/MEM stage in front of data memory: latches operands, owns SP,
// decodes RD/WR/S2/S5/pc_load and flags stack overflow/underflow.
// Ports: clk, rst (async high); ex_* EX-side inputs; stall/flush;
// SP_out/R0_out/RN_out/NPC_out memory address/data; RD/WR/S2/S5
// memory controls; mem_valid/mem_op/pc_load to WB; stack_ovf/unf sticky.
module ex_mem_stack_unit #(
  parameter logic [7:0] SP_RESET = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [2:0] ex_mem_op,
  input  logic [7:0] ex_r0,
  input  logic [7:0] ex_rn,
  input  logic [7:0] ex_npc,
  input  logic       stall,
  input  logic       flush,
  output logic [7:0] SP_out,
  output logic [7:0] R0_out,
  output logic [7:0] RN_out,
  output logic [7:0] NPC_out,
  output logic       RD,
  output logic       WR,
  output logic       S2,
  output logic       S5,
  output logic       mem_valid,
  output logic [2:0] mem_op,
  output logic       pc_load,
  output logic       stack_ovf,
  output logic       stack_unf
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  logic       valid_q;
  logic [2:0] op_q;
  logic [7:0] r0_q;
  logic [7:0] rn_q;
  logic [7:0] npc_q;
  logic [7:0] sp_q;
  logic       ovf_q;
  logic       unf_q;

  logic       full;
  logic       empty;
  logic       is_dec;
  logic       is_inc;

  assign full  = (sp_q == SP_LIMIT);
  assign empty = (sp_q == SP_RESET);

  // Stack ops that move SP when they leave MEM.
  assign is_dec = valid_q &&
                  (op_q == OP_PUSH || op_q == OP_CALL);
  assign is_inc = valid_q &&
                  (op_q == OP_POP || op_q == OP_RET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_NOP;
      r0_q    <= 8'h00;
      rn_q    <= 8'h00;
      npc_q   <= 8'h00;
      sp_q    <= SP_RESET;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
        op_q    <= OP_NOP;
      end else if (!stall) begin
        valid_q <= ex_valid;
        op_q    <= ex_valid ? ex_mem_op : OP_NOP;
        r0_q    <= ex_r0;
        rn_q    <= ex_rn;
        npc_q   <= ex_npc;
      end
      // The op already in MEM commits even when flush hits this edge.
      if (!stall) begin
        if (is_dec) begin
          if (full) ovf_q <= 1'b1;
          else      sp_q  <= sp_q - 8'd1;
        end
        if (is_inc) begin
          if (empty) unf_q <= 1'b1;
          else       sp_q  <= sp_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    RD      = 1'b0;
    WR      = 1'b0;
    S2      = 1'b0;
    S5      = 1'b0;
    pc_load = 1'b0;
    SP_out  = sp_q;
    if (valid_q) begin
      unique case (op_q)
        OP_LOAD: RD = 1'b1;
        OP_STORE: begin
          WR = 1'b1;
          S5 = 1'b1;
        end
        OP_PUSH: begin
          WR     = !full;
          S2     = 1'b1;
          S5     = 1'b1;
          SP_out = sp_q - 8'd1;
        end
        OP_CALL: begin
          WR     = !full;
          S2     = 1'b1;
          SP_out = sp_q - 8'd1;
        end
        OP_POP: begin
          RD = !empty;
          S2 = 1'b1;
        end
        OP_RET: begin
          RD      = !empty;
          S2      = 1'b1;
          pc_load = !empty;
        end
        default: ;
      endcase
    end
  end

  assign R0_out    = r0_q;
  assign RN_out    = rn_q;
  assign NPC_out   = npc_q;
  assign mem_valid = valid_q;
  assign mem_op    = op_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_ex_mem_stack_unit.sv
// Directed bench for ex_mem_stack_unit: vector table plus hand
// sequences for async reset, overflow and underflow.
module tb_ex_mem_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic [2:0] ex_mem_op;
  logic [7:0] ex_r0, ex_rn, ex_npc;
  logic       stall, flush;
  logic [7:0] SP_out, R0_out, RN_out, NPC_out;
  logic       RD, WR, S2, S5;
  logic       mem_valid;
  logic [2:0] mem_op;
  logic       pc_load, stack_ovf, stack_unf;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ex_mem_stack_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_r0(ex_r0), .ex_rn(ex_rn), .ex_npc(ex_npc),
    .stall(stall), .flush(flush),
    .SP_out(SP_out), .R0_out(R0_out),
    .RN_out(RN_out), .NPC_out(NPC_out),
    .RD(RD), .WR(WR), .S2(S2), .S5(S5),
    .mem_valid(mem_valid), .mem_op(mem_op),
    .pc_load(pc_load),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  typedef struct {
    logic       ev;
    logic [2:0] op;
    logic [7:0] r0, rn, npc;
    logic       st, fl;
    logic       mv;
    logic [2:0] mop;
    logic [7:0] sp;
    logic       rd, wr, s2, s5, pl;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(
    input logic ev, input logic [2:0] op,
    input logic [7:0] r0, input logic [7:0] rn,
    input logic [7:0] npc, input logic st, input logic fl,
    input logic mv, input logic [2:0] mop,
    input logic [7:0] sp, input logic rd, input logic wr,
    input logic s2, input logic s5, input logic pl);
    vec_t v;
    v.ev = ev; v.op = op; v.r0 = r0; v.rn = rn;
    v.npc = npc; v.st = st; v.fl = fl; v.mv = mv;
    v.mop = mop; v.sp = sp; v.rd = rd; v.wr = wr;
    v.s2 = s2; v.s5 = s5; v.pl = pl;
    return v;
  endfunction

  // got/exp packing: mv mop sp rd wr s2 s5 pl ovf unf
  function automatic logic [18:0] got_ctl();
    return {mem_valid, mem_op, SP_out, RD, WR, S2, S5,
            pc_load, stack_ovf, stack_unf};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, exp);
  endtask

  task automatic drive(input logic ev, input logic [2:0] op,
                       input logic [7:0] r0, input logic [7:0] rn,
                       input logic [7:0] npc,
                       input logic st, input logic fl);
    ex_valid = ev; ex_mem_op = op; ex_r0 = r0;
    ex_rn = rn; ex_npc = npc; stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [7:0] m_r0, m_rn, m_npc;
  logic [7:0] sp_m;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    check("reset_state", 32'(got_ctl()),
          32'({1'b0, 3'd0, 8'hFF, 7'd0}));
    check("reset_ops", {8'h0, R0_out, RN_out, NPC_out}, 32'h0);

    // ev op r0 rn npc st fl | mv mop sp rd wr s2 s5 pl
    tbl[0]  = mk(1,3,8'h00,8'h5A,8'h00,0,0, 1,3,8'hFE,0,1,1,1,0);
    tbl[1]  = mk(1,3,8'h00,8'hA5,8'h00,0,0, 1,3,8'hFD,0,1,1,1,0);
    tbl[2]  = mk(1,4,8'h00,8'h00,8'h00,0,0, 1,4,8'hFD,1,0,1,0,0);
    tbl[3]  = mk(1,4,8'h00,8'h00,8'h00,0,0, 1,4,8'hFE,1,0,1,0,0);
    tbl[4]  = mk(0,0,8'h00,8'h00,8'h00,0,0, 0,0,8'hFF,0,0,0,0,0);
    tbl[5]  = mk(1,5,8'h00,8'h00,8'h20,0,0, 1,5,8'hFE,0,1,1,0,0);
    tbl[6]  = mk(1,6,8'h00,8'h00,8'h00,0,0, 1,6,8'hFE,1,0,1,0,1);
    tbl[7]  = mk(0,0,8'h00,8'h00,8'h00,0,0, 0,0,8'hFF,0,0,0,0,0);
    tbl[8]  = mk(1,2,8'h10,8'h33,8'h00,0,0, 1,2,8'hFF,0,1,0,1,0);
    tbl[9]  = mk(1,1,8'h55,8'h66,8'h00,1,0, 1,2,8'hFF,0,1,0,1,0);
    tbl[10] = mk(1,1,8'h55,8'h66,8'h00,1,0, 1,2,8'hFF,0,1,0,1,0);
    tbl[11] = mk(1,1,8'h55,8'h66,8'h00,1,0, 1,2,8'hFF,0,1,0,1,0);
    tbl[12] = mk(1,1,8'h10,8'h00,8'h00,0,0, 1,1,8'hFF,1,0,0,0,0);
    tbl[13] = mk(1,2,8'h20,8'h44,8'h00,0,0, 1,2,8'hFF,0,1,0,1,0);
    tbl[14] = mk(1,3,8'h00,8'h99,8'h00,0,1, 0,0,8'hFF,0,0,0,0,0);
    tbl[15] = mk(1,3,8'h00,8'h77,8'h00,0,0, 1,3,8'hFE,0,1,1,1,0);
    tbl[16] = mk(1,4,8'h00,8'h00,8'h00,0,1, 0,0,8'hFE,0,0,0,0,0);
    tbl[17] = mk(1,4,8'h00,8'h00,8'h00,0,0, 1,4,8'hFE,1,0,1,0,0);
    tbl[18] = mk(0,0,8'h00,8'h00,8'h00,0,0, 0,0,8'hFF,0,0,0,0,0);
    tbl[19] = mk(1,7,8'h00,8'h00,8'h00,0,0, 1,7,8'hFF,0,0,0,0,0);
    tbl[20] = mk(0,0,8'h00,8'h00,8'h00,0,0, 0,0,8'hFF,0,0,0,0,0);
    tbl[21] = mk(1,3,8'h00,8'h11,8'h00,0,0, 1,3,8'hFE,0,1,1,1,0);
    tbl[22] = mk(1,4,8'h00,8'h00,8'h00,1,0, 1,3,8'hFE,0,1,1,1,0);
    tbl[23] = mk(0,0,8'h00,8'h00,8'h00,0,0, 0,0,8'hFE,0,0,0,0,0);
    tbl[24] = mk(1,4,8'h00,8'h00,8'h00,0,0, 1,4,8'hFE,1,0,1,0,0);
    tbl[25] = mk(0,0,8'h00,8'h00,8'h00,0,0, 0,0,8'hFF,0,0,0,0,0);

    m_r0 = 0; m_rn = 0; m_npc = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].ev, tbl[i].op, tbl[i].r0, tbl[i].rn,
            tbl[i].npc, tbl[i].st, tbl[i].fl);
      if (!tbl[i].st && !tbl[i].fl) begin
        m_r0 = tbl[i].r0; m_rn = tbl[i].rn; m_npc = tbl[i].npc;
      end
      tick();
      check($sformatf("vec%0d_ctl", i), 32'(got_ctl()),
            32'({tbl[i].mv, tbl[i].mop, tbl[i].sp, tbl[i].rd,
                 tbl[i].wr, tbl[i].s2, tbl[i].s5, tbl[i].pl,
                 2'b00}));
      if (tbl[i].mv)
        check($sformatf("vec%0d_ops", i),
              {8'h0, R0_out, RN_out, NPC_out},
              {8'h0, m_r0, m_rn, m_npc});
    end

    // Async reset in the middle of a cycle with PUSH in MEM.
    drive(1, 3, 8'h00, 8'hC3, 8'h00, 0, 0);
    tick();
    check("rst_pre_wr", 32'(WR), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async", 32'(got_ctl()),
          32'({1'b0, 3'd0, 8'hFF, 7'd0}));
    #2 rst = 1'b0;
    tick();
    check("rst_after", 32'(got_ctl()),
          32'({1'b0, 3'd0, 8'hFF, 7'd0}));

    // Fill the stack down to SP_LIMIT, then one more push.
    sp_m = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      drive(1, 3, 8'h00, 8'(i), 8'h00, 0, 0);
      tick();
      if (i > 0) sp_m = sp_m - 8'd1;
      if (i == 62)
        check("push63_wr", {WR, SP_out}, {1'b1, 8'hC0});
      if (i == 63) begin
        check("push64_wr_blocked", 32'(WR), 32'd0);
        check("push64_sp", 32'(dut.sp_q), 32'(sp_m));
        check("ovf_not_yet", 32'(stack_ovf), 32'd0);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("ovf_set", {stack_ovf, SP_out}, {1'b1, 8'hC0});
    tick();
    check("ovf_sticky", {stack_ovf, stack_unf}, 2'b10);

    // Underflow from an empty stack: POP then RET.
    do_reset();
    check("ovf_clr_rst", 32'(stack_ovf), 32'd0);
    drive(1, 4, 0, 0, 0, 0, 0);
    tick();
    check("pop_unf_ctl", {RD, S2, SP_out}, {1'b0, 1'b1, 8'hFF});
    drive(1, 6, 0, 0, 0, 0, 0);
    tick();
    check("unf_set", {stack_unf, SP_out}, {1'b1, 8'hFF});
    check("ret_unf_ctl", {RD, pc_load, S2}, {1'b0, 1'b0, 1'b1});
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("unf_sticky", {stack_unf, stack_ovf, SP_out},
          {1'b1, 1'b0, 8'hFF});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_mem_stack_unit.md
Name: ex_mem_stack_unit

Overview:
- EX/MEM pipeline stage that sits directly upstream of the data memory.
- Latches EX-stage operands and the memory-operation class, and owns the stack pointer.
- Generates every data-memory control and address/data-select input: SP, R0, RN, NPC, RD, WR, S2, S5.
- Handles stall/flush and detects stack overflow and underflow.

Parameters:
- SP_RESET, 8'hFF: stack pointer value when the stack is empty. The stack is full-descending; SP points at the last pushed byte.
- SP_LIMIT, 8'hC0: lowest legal stack address. A push when sp == SP_LIMIT overflows.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_mem_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved (treated as NOP).
- ex_r0  in  8  address operand for LOAD/STORE.
- ex_rn  in  8  store/push data.
- ex_npc  in  8  next-PC, used as CALL return address.
- stall  in  1  freeze this stage (hold all registers and SP).
- flush  in  1  replace the captured instruction with a bubble.
- SP_out  out  8  stack address to data memory.
- R0_out  out  8  latched ex_r0.
- RN_out  out  8  latched ex_rn.
- NPC_out  out  8  latched ex_npc.
- RD  out  1  memory read.
- WR  out  1  memory write.
- S2  out  1  address select: 1 = SP_out, 0 = R0_out.
- S5  out  1  data select: 1 = RN_out, 0 = NPC_out.
- mem_valid  out  1  MEM stage holds a real instruction.
- mem_op  out  3  latched op class, for WB.
- pc_load  out  1  RET in MEM; dataOut is the new PC.
- stack_ovf  out  1  sticky overflow flag.
- stack_unf  out  1  sticky underflow flag.

Behaviour:
- Reset (async, immediate):
  - mem_valid=0, mem_op=0, R0/RN/NPC regs=0, sp=SP_RESET.
  - stack_ovf=0, stack_unf=0.
  - Consequently RD=WR=S2=S5=pc_load=0 and SP_out=SP_RESET.
  - Reset asserted mid-operation abandons the in-flight op; no SP change survives.
- Pipeline register, updated on each posedge, priority flush > stall > load:
  - flush: mem_valid<=0, mem_op<=0; operand regs don't-care; sp unchanged.
  - stall (no flush): everything holds, including sp.
  - otherwise: mem_valid<=ex_valid; mem_op<=ex_valid ? ex_mem_op : 0; operands <= ex_* inputs.
- Control decode is combinational from the latched op, and every output is 0 unless mem_valid=1:
  - LOAD: RD=1, S2=0.
  - STORE: WR=1, S2=0, S5=1.
  - PUSH: WR=1, S2=1, S5=1, SP_out=sp-1.
  - CALL: WR=1, S2=1, S5=0, SP_out=sp-1.
  - POP: RD=1, S2=1, SP_out=sp.
  - RET: RD=1, S2=1, SP_out=sp, pc_load=1.
  - NOP / reserved: all controls 0.
  - In all other cases SP_out=sp.
  - All SP arithmetic is 8-bit modulo.
- SP commit happens on the posedge that ends the MEM cycle, and only when mem_valid=1 and stall=0:
  - PUSH/CALL: sp<=sp-1.
  - POP/RET: sp<=sp+1.
  - flush on that edge does not cancel the commit of the instruction already in MEM.
  - While stall=1, WR repeats to the same address with the same data (idempotent); sp does not move.
- Overflow: PUSH/CALL with sp==SP_LIMIT forces WR=0 and leaves sp unchanged; stack_ovf<=1 at the commit edge.
- Underflow: POP/RET with sp==SP_RESET forces RD=0 and pc_load=0 and leaves sp unchanged; stack_unf<=1 at the commit edge.
- stack_ovf and stack_unf clear only on rst.
- Latency:
  - EX inputs appear on the outputs 1 cycle after capture.
  - Back-to-back stack ops need no bubble, because sp is updated on the same edge the next op enters MEM.

Test Plan:
- rst pulse mid-cycle with PUSH in MEM -> outputs drop immediately; after release SP_out=8'hFF, WR=0, stack flags=0.
- PUSH rn=8'h5A, then PUSH rn=8'hA5, then POP, POP back-to-back -> writes at FE/FD; reads FD then FE (A5, 5A); final sp=FF; S2=1 throughout; S5=1 on the pushes.
- CALL npc=8'h20 then RET -> write addr FE with S5=0, data 20; RET has RD=1, pc_load=1, SP_out=FE; sp returns to FF.
- STORE r0=8'h10 rn=8'h33 with stall held 3 cycles -> WR=1, S2=0, S5=1, R0_out=10 for 4 cycles; then LOAD r0=10 -> RD=1, S2=0; sp stays FF.
- Push 63 times to reach sp=C0, then PUSH again -> 64th push has WR=0, stack_ovf=1, sp stays C0. Then from reset, POP -> RD=0, stack_unf=1, sp stays FF.
- flush asserted while ex_valid=1 PUSH, while a STORE is in MEM -> STORE completes normally; next cycle mem_valid=0, WR=0, sp unchanged.
